// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline control unit for the 5-stage lw/sw datapath. It tracks in-flight
// register writes in the EX, MEM and WB stages, detects read-after-write
// hazards against the instruction in ID, and drives the PC and pipeline
// register enables. It also inserts bubbles into ID/EX, freezes on
// data-memory wait or host halt, and counts stall cycles.
//
// Build option:
//   PIPE_FWD_EN - datapath has EX/MEM-to-EX forwarding; only a load sitting in
//                 EX can hazard. Undefined: the full EX/MEM/WB scoreboard stalls.
//
// Parameters:
//   CNT_W       - width of the saturating stall counter
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   run                  - host run enable (0 freezes the pipeline)
//   mem_busy             - data memory not ready (freezes the pipeline)
//   cnt_clr              - synchronous clear of stall_cnt
//   id_valid             - ID holds a real instruction
//   id_use_rs0/rs1       - instruction reads rs0 / rs1
//   id_rs0, id_rs1       - source register addresses
//   id_wreg_en           - instruction writes a register
//   id_mem_rd            - instruction is a load
//   id_wreg              - destination register
//   en_pc .. en_mem      - enables for PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//   bubble_id            - ID/EX loads a bubble this cycle
//   state                - condition of the previous cycle (debug view)
//   stall_cnt            - cycles spent in RAW or MEM_WAIT, saturating
//
// Handshake note: there is no valid/ready pair here. en_id acts as the
// "ready" for the ID stage: an instruction in ID is consumed at the clock
// edge in which the condition is RUN; in RAW it stays in ID and ID/EX takes
// a bubble; in HALT and MEM_WAIT nothing moves.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  input  logic             id_valid,
  input  logic             id_use_rs0,
  input  logic             id_use_rs1,
  input  logic [3:0]       id_rs0,
  input  logic [3:0]       id_rs1,
  input  logic             id_wreg_en,
  input  logic             id_mem_rd,
  input  logic [3:0]       id_wreg,
  output logic             en_pc,
  output logic             en_if,
  output logic             en_id,
  output logic             en_ex,
  output logic             en_mem,
  output logic             bubble_id,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    C_HALT     = 2'd0,
    C_RUN      = 2'd1,
    C_RAW      = 2'd2,
    C_MEM_WAIT = 2'd3
  } cond_t;

  typedef struct packed {
    logic       v;
    logic [3:0] wreg;
    logic       load;
  } slot_t;

  slot_t ex_q, mem_q, wb_q;
  cond_t cond, state_q;
  logic  hazard;

  // A slot matches when it holds a valid write to a register ID reads.
  function automatic logic slot_match(input slot_t s);
    return s.v && id_valid &&
           ((id_use_rs0 && (s.wreg == id_rs0)) ||
            (id_use_rs1 && (s.wreg == id_rs1)));
  endfunction

`ifdef PIPE_FWD_EN
  // Forwarding covers everything except a load still in EX: its data only
  // exists after MEM, so the consumer waits exactly one cycle.
  assign hazard = slot_match(ex_q) && ex_q.load;

  // MEM/WB load bits are kept for a complete pipeline picture but not read.
  logic unused_load;
  assign unused_load = mem_q.load ^ wb_q.load;
`else
  // No forwarding and no write-bypass in the register file: ID waits until
  // the producer has left WB.
  assign hazard = slot_match(ex_q) || slot_match(mem_q) || slot_match(wb_q);

  logic unused_load;
  assign unused_load = ex_q.load ^ mem_q.load ^ wb_q.load;
`endif

  // Condition and enables, zero latency from inputs and scoreboard.
  always_comb begin
    cond      = C_RUN;
    en_pc     = 1'b1;
    en_if     = 1'b1;
    en_id     = 1'b1;
    en_ex     = 1'b1;
    en_mem    = 1'b1;
    bubble_id = 1'b0;
    if (!run) begin
      cond   = C_HALT;
      en_pc  = 1'b0;
      en_if  = 1'b0;
      en_id  = 1'b0;
      en_ex  = 1'b0;
      en_mem = 1'b0;
    end else if (mem_busy) begin
      cond   = C_MEM_WAIT;
      en_pc  = 1'b0;
      en_if  = 1'b0;
      en_id  = 1'b0;
      en_ex  = 1'b0;
      en_mem = 1'b0;
    end else if (hazard) begin
      // Hold PC and IF/ID, let the back end drain, inject a bubble.
      cond      = C_RAW;
      en_pc     = 1'b0;
      en_if     = 1'b0;
      bubble_id = 1'b1;
    end
  end

  // Scoreboard shifts with the pipeline; a RAW cycle shifts in a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      case (cond)
        C_RUN: begin
          wb_q  <= mem_q;
          mem_q <= ex_q;
          ex_q  <= '{v: id_valid & id_wreg_en, wreg: id_wreg, load: id_mem_rd};
        end
        C_RAW: begin
          wb_q   <= mem_q;
          mem_q  <= ex_q;
          ex_q.v <= 1'b0;
        end
        default: ;  // HALT and MEM_WAIT hold every slot
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= C_HALT;
    else        state_q <= cond;
  end

  assign state = state_q;

  // Clear wins over increment; increment stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (((cond == C_RAW) || (cond == C_MEM_WAIT)) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the 5-stage lw/sw datapath. It keeps a scoreboard of in-flight register writes in the EX, MEM and WB stages. From that scoreboard it detects read-after-write hazards against the instruction in ID. It drives the enables of the PC and of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB), and inserts bubbles into ID/EX. It also freezes the pipeline on data-memory wait or host halt, and counts stall cycles.

## Interface
Parameters:
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  host run enable; 0 freezes pipeline
- mem_busy  in  1  data memory not ready this cycle; freezes pipeline
- cnt_clr  in  1  synchronous clear of stall_cnt
- id_valid  in  1  ID holds a real instruction
- id_use_rs0, id_use_rs1  in  1 each  instruction reads rs0 / rs1
- id_rs0, id_rs1  in  4 each  source register addresses
- id_wreg_en  in  1  instruction writes a register (WRegEn)
- id_mem_rd  in  1  instruction is a load
- id_wreg  in  4  destination register (WReg1)
- en_pc, en_if, en_id, en_ex, en_mem  out  1 each  register enables: PC, IF/ID, ID/EX, EX/MEM, MEM/WB
- bubble_id  out  1  ID/EX loads WRegEn=0, WMemEn=0 this cycle
- state  out  2  registered condition of previous cycle: 0 HALT, 1 RUN, 2 RAW, 3 MEM_WAIT
- stall_cnt  out  CNT_W  cycles spent in RAW or MEM_WAIT, saturating

## Operation
- Scoreboard: three slots ex/mem/wb. Each slot holds {v, wreg[3:0], load}. All 16 registers are real; r0 is not hardwired to zero.
- Hazard match: the stage slot is valid, its wreg equals a used source, and id_valid=1.
- Without FORWARD_EN, hazard = match in ex, mem or wb. The register file is not write-bypassed, so ID waits until the producer has left WB.
- Condition priority, evaluated every cycle, combinational from inputs and scoreboard:
  - HALT (run=0): all en_* = 0, bubble_id = 0.
  - MEM_WAIT (mem_busy=1): all en_* = 0, bubble_id = 0.
  - RAW (hazard): en_pc = en_if = 0; en_id = en_ex = en_mem = 1; bubble_id = 1.
  - RUN (otherwise): all en_* = 1, bubble_id = 0.
- Scoreboard update at posedge:
  - RUN: wb<-mem, mem<-ex, ex<-{id_valid&id_wreg_en, id_wreg, id_mem_rd}.
  - RAW: wb<-mem, mem<-ex, ex.v<-0.
  - HALT and MEM_WAIT: hold all slots.
- state register <= condition code each clk.
- stall_cnt increments in RAW or MEM_WAIT and saturates at all-ones. cnt_clr takes priority over increment.

## Timing
- Reset values: scoreboard all invalid, state = 0 (HALT), stall_cnt = 0.
- Enables during reset: en_* and bubble_id follow the combinational rules. With run=0 they are all 0.
- Enables and bubble_id have zero latency: they respond in the same cycle to ID inputs, mem_busy and run.
- state lags the applied condition by one cycle.
- Non-forwarded stall length: the producer sits at distance d stages ahead (EX=1). A consumer entering ID right behind it stalls 3 RAW cycles, assuming no mem_busy.
- Forwarded stall length: a load-use pair stalls exactly 1 RAW cycle. Non-load dependents stall 0 cycles.
- Simultaneous mem_busy and hazard gives MEM_WAIT. The hazard is re-evaluated once mem_busy drops, with an unchanged scoreboard.
- run=0 during RAW or MEM_WAIT: the unit freezes and resumes with the same scoreboard.
- rst_n asserted mid-stall: the scoreboard clears. The next instruction in ID then sees no hazard.
- id_valid=0 or no used sources never gives RAW.
- The same register appearing in multiple slots is a single hazard.

## Configuration
- PIPE_FWD_EN defined: the datapath has EX/MEM-to-EX forwarding. Hazard = match in ex slot with ex.load=1 only. The mem and wb slots are not checked for hazard but are still tracked.
- PIPE_FWD_EN undefined: full scoreboard stall as above.

## Test plan
- Reset with run=1 and empty pipe, then lw r2 with no dependence -> RUN; all en_*=1; state=1 the next cycle; stall_cnt=0.
- lw r3, then an sw reading r3 on the next cycle, PIPE_FWD_EN undefined -> 3 cycles of en_pc=0 with bubble_id=1, then RUN; stall_cnt=3.
- Same sequence with PIPE_FWD_EN defined -> 1 RAW cycle; stall_cnt=1. Non-load producer followed by a dependent -> 0 stalls.
- mem_busy=1 for 4 cycles while a hazard is pending -> all en_*=0 for 4 cycles; state=3; scoreboard held. Then the remaining RAW cycles complete; stall_cnt=4+RAW cycles.
- run=0 for 2 cycles mid-RAW, then run=1 -> en_*=0 and state=0 during the halt; the stall then resumes with unchanged remaining count; stall_cnt does not count HALT.
- Force stall_cnt to saturate with CNT_W=4 (16+ stall cycles) -> it holds at 4'hF. cnt_clr during a stall -> 0 the next cycle. rst_n pulse mid-stall -> en_pc=1 as soon as run=1.
